gshare_predictor: RTL

// Global-history (gshare) direction predictor feeding the tournament chooser as its

---
 rtl/gshare_predictor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// GsharePredictor : global-history (gshare) branch direction predictor.
//
// The fetch PC is XOR-hashed with a speculative global history register
// (GHR) to index a table of 2-bit saturating counters. The prediction is
// registered and appears one cycle after the lookup. Resolved branches
// train the table. A misprediction restores the GHR from the history
// snapshot that travelled down the pipe with the branch.
//
// After reset an INIT sweep writes every counter to weakly not-taken. The
// sweep takes one entry per cycle. Lookups and updates are ignored until
// the sweep finishes and ready rises.
//
// Ports
//   clk            : clock, all state changes on posedge
//   rst_n          : asynchronous active-low reset
//   ready          : table initialised, lookups/updates accepted
//   lookup_valid   : conditional branch fetched this cycle
//   lookup_pc      : fetch PC bits [13:2]; low IDX_W bits used
//   pred_valid     : prediction valid (one cycle after accepted lookup)
//   pred_taken     : predicted direction
//   pred_index     : table index used by the prediction
//   pred_ghr       : GHR value before this branch's speculative shift
//   upd_valid      : resolved conditional branch this cycle
//   upd_index      : pred_index returned with the resolved branch
//   upd_taken      : actual direction
//   upd_mispredict : predicted direction was wrong, restore GHR
//   upd_ghr        : pred_ghr returned with the resolved branch
// ---------------------------------------------------------------------------
module gshare_predictor #(
  parameter int IDX_W  = 12,
  parameter int HIST_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              lookup_valid,
  input  logic [11:0]       lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_index,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [HIST_W-1:0] upd_ghr
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  sweepPtr_q;
  logic              ready_q;
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic              predValid_q;
  logic              predTaken_q;
  logic [IDX_W-1:0]  predIndex_q;
  logic [HIST_W-1:0] predGhr_q;

  // Counter table. It has no reset, because the INIT sweep initialises it.
  logic [1:0] counterTable_q [DEPTH];

  logic              running;
  logic              updEn;
  logic              recoverEn;
  logic              lookupEn;
  logic [IDX_W-1:0]  lookupIdx;
  logic [1:0]        updCur;
  logic [1:0]        updNew;
  logic [1:0]        readCtr;
  logic              predBit;
  logic [HIST_W-1:0] ghrShifted;
  logic [HIST_W-1:0] ghrRecovered;

  assign running   = (state_q == ST_RUN);
  assign updEn     = running & upd_valid;
  assign recoverEn = updEn & upd_mispredict;
  // A recovering update redirects fetch, so a lookup in the same cycle is dropped.
  assign lookupEn  = running & lookup_valid & ~recoverEn;
  assign lookupIdx = lookup_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);

  always_comb begin
    updCur = counterTable_q[upd_index];
    updNew = updCur;
    if (upd_taken) begin
      if (updCur != 2'b11) updNew = updCur + 2'd1;
    end else begin
      if (updCur != 2'b00) updNew = updCur - 2'd1;
    end
  end

  // A same-cycle update to the looked-up entry is forwarded.
  // The prediction and the speculative shift then both use the trained value.
  always_comb begin
    readCtr = counterTable_q[lookupIdx];
    if (updEn && (upd_index == lookupIdx)) readCtr = updNew;
  end

  assign predBit = readCtr[1];

  // With a 1-bit history the shift register collapses to the newest direction.
  generate
    if (HIST_W == 1) begin : gHist1
      assign ghrShifted   = predBit;
      assign ghrRecovered = upd_taken;
    end else begin : gHistN
      assign ghrShifted   = {ghr_q[HIST_W-2:0], predBit};
      assign ghrRecovered = {upd_ghr[HIST_W-2:0], upd_taken};
    end
  endgenerate

  always_comb begin
    ghr_d = ghr_q;
    if (recoverEn)     ghr_d = ghrRecovered;
    else if (lookupEn) ghr_d = ghrShifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweepPtr_q  <= '0;
      ready_q     <= 1'b0;
      ghr_q       <= '0;
      predValid_q <= 1'b0;
      predTaken_q <= 1'b0;
      predIndex_q <= '0;
      predGhr_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweepPtr_q <= sweepPtr_q + 1'b1;
          if (sweepPtr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: state_q <= ST_INIT;
      endcase

      ghr_q       <= ghr_d;
      predValid_q <= lookupEn;
      if (lookupEn) begin
        predTaken_q <= predBit;
        predIndex_q <= lookupIdx;
        predGhr_q   <= ghr_q;
      end
    end
  end

  // This is the single write port. The sweep owns it during INIT, and training owns it during RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      counterTable_q[sweepPtr_q] <= 2'b01;
    end else if (updEn) begin
      counterTable_q[upd_index] <= updNew;
    end
  end

  assign ready      = ready_q;
  assign pred_valid = predValid_q;
  assign pred_taken = predTaken_q;
  assign pred_index = predIndex_q;
  assign pred_ghr   = predGhr_q;

endmodule
